// File: rtl/dpram_arbiter_if.sv
// Requester-side bus of the dual-port vector RAM arbiter.
// The master drives requests; the slave returns grants and read data.
interface dpram_arbiter_if #(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned VECTOR_BITS = 64,
   parameter int unsigned ADDR_BITS   = 5
);
   logic [NUM_REQ-1:0]             req;
   logic [NUM_REQ-1:0]             we;
   logic [NUM_REQ*ADDR_BITS-1:0]   addr;
   logic [NUM_REQ*VECTOR_BITS-1:0] wdata;
   logic [NUM_REQ-1:0]             gnt;
   logic [NUM_REQ-1:0]             rvalid;
   logic [NUM_REQ*VECTOR_BITS-1:0] rdata;

   modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dpram_arbiter.sv
// Round-robin arbiter sharing one dual-port vector RAM between NUM_REQ requesters.
// Up to two non-conflicting accesses per cycle; read data returns one cycle after grant.
module dpram_arbiter #(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned VECTOR_BITS = 64,
   parameter int unsigned ADDR_BITS   = 5
) (
   input  logic                   clk,
   input  logic                   resetn,
   dpram_arbiter_if.slave         bus,
   output logic [ADDR_BITS-1:0]   address_a,
   output logic [ADDR_BITS-1:0]   address_b,
   output logic                   wren_a,
   output logic                   wren_b,
   output logic [VECTOR_BITS-1:0] data_a,
   output logic [VECTOR_BITS-1:0] data_b,
   input  logic [VECTOR_BITS-1:0] out_a,
   input  logic [VECTOR_BITS-1:0] out_b
);
   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
   logic [IDX_W-1:0] win_a, win_b;
   logic             found_a, found_b;
   logic             own_a_vld, own_b_vld;
   logic [IDX_W-1:0] own_a_idx, own_b_idx;

   // Scan from rr_ptr; B must not touch A's address unless both are reads.
   always_comb begin
      int unsigned idx;
      idx     = 0;
      found_a = 1'b0;
      found_b = 1'b0;
      win_a   = '0;
      win_b   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = (32'(rr_ptr) + k) % NUM_REQ;
         if (resetn && bus.req[idx]) begin
            if (!found_a) begin
               found_a = 1'b1;
               win_a   = IDX_W'(idx);
            end else if (!found_b &&
                         !((bus.addr[idx*ADDR_BITS +: ADDR_BITS] ==
                            bus.addr[32'(win_a)*ADDR_BITS +: ADDR_BITS]) &&
                           (bus.we[idx] || bus.we[win_a]))) begin
               found_b = 1'b1;
               win_b   = IDX_W'(idx);
            end
         end
      end
   end

   // Winners drive RAM ports; idle ports stay at zero with write disabled.
   always_comb begin
      bus.gnt   = '0;
      address_a = '0;
      address_b = '0;
      wren_a    = 1'b0;
      wren_b    = 1'b0;
      data_a    = '0;
      data_b    = '0;
      if (found_a) begin
         bus.gnt[win_a] = 1'b1;
         address_a      = bus.addr[32'(win_a)*ADDR_BITS +: ADDR_BITS];
         wren_a         = bus.we[win_a];
         data_a         = bus.wdata[32'(win_a)*VECTOR_BITS +: VECTOR_BITS];
      end
      if (found_b) begin
         bus.gnt[win_b] = 1'b1;
         address_b      = bus.addr[32'(win_b)*ADDR_BITS +: ADDR_BITS];
         wren_b         = bus.we[win_b];
         data_b         = bus.wdata[32'(win_b)*VECTOR_BITS +: VECTOR_BITS];
      end
   end

   always_comb begin
      rr_ptr_nxt = rr_ptr;
      if (found_b)
         rr_ptr_nxt = IDX_W'((32'(win_b) + 1) % NUM_REQ);
      else if (found_a)
         rr_ptr_nxt = IDX_W'((32'(win_a) + 1) % NUM_REQ);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rr_ptr    <= '0;
         own_a_vld <= 1'b0;
         own_b_vld <= 1'b0;
         own_a_idx <= '0;
         own_b_idx <= '0;
      end else begin
         rr_ptr    <= rr_ptr_nxt;
         own_a_vld <= found_a && !wren_a;
         own_b_vld <= found_b && !wren_b;
         own_a_idx <= win_a;
         own_b_idx <= win_b;
      end
   end

   // Route the registered RAM outputs back to the requester that owns each port.
   always_comb begin
      bus.rvalid = '0;
      bus.rdata  = '0;
      if (own_a_vld) begin
         bus.rvalid[own_a_idx]                                = 1'b1;
         bus.rdata[32'(own_a_idx)*VECTOR_BITS +: VECTOR_BITS] = out_a;
      end
      if (own_b_vld) begin
         bus.rvalid[own_b_idx]                                = 1'b1;
         bus.rdata[32'(own_b_idx)*VECTOR_BITS +: VECTOR_BITS] = out_b;
      end
   end
endmodule

// File: tb/tb_dpram_arbiter.sv
// Self-checking bench for dpram_arbiter: directed scenarios then random traffic,
// compared against a behavioural arbitration/memory model.
module tb_dpram_arbiter;
   localparam int NR = 4;
   localparam int VB = 64;
   localparam int AB = 5;
   localparam int W  = NR*VB;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic [AB-1:0] address_a, address_b;
   logic          wren_a, wren_b;
   logic [VB-1:0] data_a, data_b, out_a, out_b;

   dpram_arbiter_if #(.NUM_REQ(NR), .VECTOR_BITS(VB), .ADDR_BITS(AB)) bus ();

   dpram_arbiter #(.NUM_REQ(NR), .VECTOR_BITS(VB), .ADDR_BITS(AB)) dut (
      .clk(clk), .resetn(resetn), .bus(bus),
      .address_a(address_a), .address_b(address_b),
      .wren_a(wren_a), .wren_b(wren_b),
      .data_a(data_a), .data_b(data_b),
      .out_a(out_a), .out_b(out_b)
   );

   always #5 clk = ~clk;

   // Dual-port RAM with registered read (read-before-write).
   logic [VB-1:0] ram [32] = '{default: '0};
   always @(posedge clk) begin
      if (wren_a) ram[address_a] <= data_a;
      if (wren_b) ram[address_b] <= data_b;
      out_a <= ram[address_a];
      out_b <= ram[address_b];
   end

   int            tests = 0;
   int            fails = 0;
   int            m_ptr;
   logic [VB-1:0] m_mem [32];
   logic          t_req [NR];
   logic          t_we [NR];
   logic [AB-1:0] t_addr [NR];
   logic [VB-1:0] t_wdata [NR];
   logic [NR-1:0] obs_gnt;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         bus.req[i]             = t_req[i];
         bus.we[i]              = t_we[i];
         bus.addr[i*AB +: AB]   = t_addr[i];
         bus.wdata[i*VB +: VB]  = t_wdata[i];
      end
   endtask

   // Order requesters from the pointer; A is the first, B the first later one with no clash.
   function automatic void pick(output int wa, output int wb);
      int order[$];
      wa = -1;
      wb = -1;
      for (int k = 0; k < NR; k++)
         if (t_req[(m_ptr + k) % NR]) order.push_back((m_ptr + k) % NR);
      if (order.size() > 0) begin
         wa = order.pop_front();
         foreach (order[j])
            if (wb < 0 && !(t_addr[order[j]] == t_addr[wa] && (t_we[order[j]] || t_we[wa])))
               wb = order[j];
      end
   endfunction

   task automatic step(input string tag);
      int            wa, wb;
      logic [NR-1:0] eg;
      logic [NR-1:0] exp_rv;
      logic [W-1:0]  exp_rd;
      drive();
      @(negedge clk);
      pick(wa, wb);
      eg = '0;
      if (wa >= 0) eg[wa] = 1'b1;
      if (wb >= 0) eg[wb] = 1'b1;
      obs_gnt = bus.gnt;
      chk({tag, ".gnt"}, W'(bus.gnt), W'(eg));
      chk({tag, ".wren_a"}, W'(wren_a), W'(wa >= 0 && t_we[wa]));
      chk({tag, ".addr_a"}, W'(address_a), (wa >= 0) ? W'(t_addr[wa]) : W'(0));
      chk({tag, ".wren_b"}, W'(wren_b), W'(wb >= 0 && t_we[wb]));
      chk({tag, ".addr_b"}, W'(address_b), (wb >= 0) ? W'(t_addr[wb]) : W'(0));
      if (wa >= 0 && t_we[wa]) chk({tag, ".data_a"}, W'(data_a), W'(t_wdata[wa]));
      if (wb >= 0 && t_we[wb]) chk({tag, ".data_b"}, W'(data_b), W'(t_wdata[wb]));
      exp_rv = '0;
      exp_rd = '0;
      if (wa >= 0 && !t_we[wa]) begin
         exp_rv[wa] = 1'b1;
         exp_rd[wa*VB +: VB] = m_mem[t_addr[wa]];
      end
      if (wb >= 0 && !t_we[wb]) begin
         exp_rv[wb] = 1'b1;
         exp_rd[wb*VB +: VB] = m_mem[t_addr[wb]];
      end
      @(posedge clk);
      if (wa >= 0 && t_we[wa]) m_mem[t_addr[wa]] = t_wdata[wa];
      if (wb >= 0 && t_we[wb]) m_mem[t_addr[wb]] = t_wdata[wb];
      if (wb >= 0) m_ptr = (wb + 1) % NR;
      else if (wa >= 0) m_ptr = (wa + 1) % NR;
      if (wa >= 0) t_req[wa] = 1'b0;
      if (wb >= 0) t_req[wb] = 1'b0;
      #1;
      chk({tag, ".rvalid"}, W'(bus.rvalid), W'(exp_rv));
      chk({tag, ".rdata"}, bus.rdata, exp_rd);
   endtask

   task automatic set_req(input int i, input logic w, input int a, input logic [VB-1:0] d);
      t_req[i]   = 1'b1;
      t_we[i]    = w;
      t_addr[i]  = AB'(a);
      t_wdata[i] = d;
   endtask

   initial begin
      int n0, n2, got;
      m_ptr = 0;
      foreach (m_mem[i]) m_mem[i] = '0;
      for (int i = 0; i < NR; i++) begin
         t_req[i] = 1'b0; t_we[i] = 1'b0; t_addr[i] = '0; t_wdata[i] = '0;
      end

      // Reset: grants gated even with a request pending
      set_req(0, 1'b1, 1, 64'h1111);
      drive();
      @(negedge clk);
      chk("rst.gnt", W'(bus.gnt), W'(0));
      chk("rst.wren", W'({wren_a, wren_b}), W'(0));
      chk("rst.addr", W'({address_a, address_b}), W'(0));
      chk("rst.data", W'({data_a, data_b}), W'(0));
      chk("rst.rvalid", W'(bus.rvalid), W'(0));
      t_req[0] = 1'b0;
      drive();
      @(posedge clk);
      #1 resetn = 1'b1;

      // Single requester: write then read back on port A
      set_req(0, 1'b1, 3, 64'hA5);
      step("t1w");
      chk("t1w.only0", W'(obs_gnt), W'(4'b0001));
      set_req(0, 1'b0, 3, '0);
      step("t1r");
      chk("t1r.only0", W'(obs_gnt), W'(4'b0001));
      chk("t1r.rvalid", W'(bus.rvalid), W'(4'b0001));
      chk("t1r.rdata", W'(bus.rdata[63:0]), W'(64'hA5));
      set_req(3, 1'b0, 3, '0);
      step("t1p");

      // Four distinct reads held: two pairs in two cycles
      for (int i = 0; i < NR; i++) set_req(i, 1'b0, 10 + i, '0);
      step("t2c1");
      chk("t2c1.pair", W'(obs_gnt), W'(4'b0011));
      step("t2c2");
      chk("t2c2.pair", W'(obs_gnt), W'(4'b1100));

      // Write/read clash on addr 7: reader waits and sees the new value
      set_req(0, 1'b1, 7, 64'hDEAD_BEEF_0000_0007);
      set_req(1, 1'b0, 7, '0);
      step("t3c1");
      chk("t3c1.writer", W'(obs_gnt), W'(4'b0001));
      step("t3c2");
      chk("t3c2.reader", W'(obs_gnt), W'(4'b0010));
      chk("t3c2.newdata", W'(bus.rdata[127:64]), W'(64'hDEAD_BEEF_0000_0007));

      // Two reads of the same address share a cycle
      set_req(0, 1'b1, 9, 64'h0123_4567_89AB_CDEF);
      step("t4w");
      set_req(2, 1'b0, 9, '0);
      set_req(3, 1'b0, 9, '0);
      step("t4r");
      chk("t4r.both", W'(obs_gnt), W'(4'b1100));
      chk("t4r.same", W'(bus.rdata[255:192]), W'(bus.rdata[191:128]));
      chk("t4r.val", W'(bus.rdata[191:128]), W'(64'h0123_4567_89AB_CDEF));

      // Fairness: req1 held against constant traffic from 0 and 2, pointer at 2
      set_req(1, 1'b0, 20, '0);
      step("t5p");
      set_req(1, 1'b0, 21, '0);
      n0 = 0; n2 = 0; got = -1;
      for (int c = 0; c < NR && got < 0; c++) begin
         set_req(0, 1'b0, 22, '0);
         set_req(2, 1'b0, 23, '0);
         step("t5");
         if (obs_gnt[1]) got = c;
         else begin
            if (obs_gnt[0]) n0++;
            if (obs_gnt[2]) n2++;
         end
      end
      chk("t5.granted", W'(got >= 0), W'(1));
      chk("t5.nodouble", W'(n0 > 1 || n2 > 1), W'(0));
      for (int i = 0; i < NR; i++) t_req[i] = 1'b0;
      step("t5d");

      // Reset during a pending read return
      set_req(1, 1'b0, 3, '0);
      step("t6r");
      #1 resetn = 1'b0;
      set_req(0, 1'b0, 4, '0);
      set_req(1, 1'b0, 5, '0);
      drive();
      #1;
      chk("t6.rst_rvalid", W'(bus.rvalid), W'(0));
      chk("t6.rst_gnt", W'(bus.gnt), W'(0));
      for (int i = 0; i < NR; i++) t_req[i] = 1'b0;
      drive();
      @(negedge clk);
      #1 resetn = 1'b1;
      m_ptr = 0;
      @(posedge clk);
      #1;
      chk("t6.post_rvalid", W'(bus.rvalid), W'(0));
      set_req(0, 1'b0, 3, '0);
      set_req(3, 1'b0, 9, '0);
      step("t6p");

      // Random traffic over a small address window to provoke clashes
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NR; i++) begin
            if (!t_req[i]) begin
               if ($urandom_range(0, 9) < 6)
                  set_req(i, $urandom_range(0, 3) == 0, $urandom_range(0, 5), {$urandom, $urandom});
            end else if ($urandom_range(0, 19) == 0) begin
               t_req[i] = 1'b0;
            end
         end
         step("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
